// File: rtl/conv_layer_engine.sv
// conv_layer_engine: streams an image and kernels from an external ROM,
// computes one saturated fixed-point feature row per FETCH pass.
// Ports: clk, rst_n (async, active low), enable (run request)
//   ext_rom_addr / ext_rom_data : ROM read, data one cycle after address
//   feature_valid / feature_ready / feature_output : row handshake
//   feature_idx, feature_row : kernel and row of the presented row
//   busy (not idle), image_calc_fin (one-cycle done pulse)
module conv_layer_engine #(
  parameter int DATA_WIDTH     = 16,
  parameter int FRAC_BITS      = 8,
  parameter int IMAGE_SIZE     = 8,
  parameter int KERNEL_SIZE    = 3,
  parameter int ARRAY_SIZE     = IMAGE_SIZE - KERNEL_SIZE + 1,
  parameter int NUM_KERNELS    = 3,
  parameter int EXT_ADDR_WIDTH = 12,
  parameter int WEIGHT_BASE    = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  output logic [EXT_ADDR_WIDTH-1:0]        ext_rom_addr,
  input  logic [DATA_WIDTH-1:0]            ext_rom_data,
  output logic                             feature_valid,
  input  logic                             feature_ready,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] feature_output,
  output logic [$clog2(NUM_KERNELS)-1:0]   feature_idx,
  output logic [$clog2(ARRAY_SIZE)-1:0]    feature_row,
  output logic                             busy,
  output logic                             image_calc_fin
);

  localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(KK) + 1;
  localparam int TW    = $clog2(KERNEL_SIZE + 1);
  localparam int PW    = $clog2(ARRAY_SIZE + 1);
  localparam int IW    = $clog2(NUM_KERNELS);
  localparam int RW    = $clog2(ARRAY_SIZE);

  localparam logic [TW-1:0] T_END  = TW'(KERNEL_SIZE);
  localparam logic [TW-1:0] T_LAST = TW'(KERNEL_SIZE - 1);
  localparam logic [PW-1:0] P_LAST = PW'(ARRAY_SIZE);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_KERNELS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ARRAY_SIZE - 1);

  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FETCH, OUTPUT, DONE} state_e;

  state_e state_q, state_d;

  logic [TW-1:0] ti_q, tj_q;
  logic [PW-1:0] pos_q, pend_pos_q;
  logic          pend_q;
  logic [IW-1:0] idx_q;
  logic [RW-1:0] row_q;

  logic signed [DATA_WIDTH-1:0]   w_q;
  logic signed [ACC_W-1:0]        acc_q [ARRAY_SIZE];
  logic signed [2*DATA_WIDTH-1:0] prod;

  logic issue, start, hs, last_row;

  // issue is low in the single drain cycle that collects the last datum
  assign issue    = (state_q == FETCH) && (ti_q != T_END);
  assign start    = (state_q == IDLE) && enable;
  assign hs       = (state_q == OUTPUT) && enable && feature_ready;
  assign last_row = (row_q == R_LAST) && (idx_q == I_LAST);
  assign prod     = $signed(ext_rom_data) * w_q;

  assign feature_valid  = (state_q == OUTPUT);
  assign busy           = (state_q != IDLE);
  assign image_calc_fin = (state_q == DONE);
  assign feature_idx    = idx_q;
  assign feature_row    = row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (enable) state_d = FETCH;
      FETCH: begin
        if (!enable)     state_d = IDLE;
        else if (!issue) state_d = OUTPUT;
      end
      OUTPUT: begin
        if (!enable)            state_d = IDLE;
        else if (feature_ready) state_d = last_row ? DONE : FETCH;
      end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // pos 0 addresses the tap weight, pos 1..A the pixels of column pos-1
  always_comb begin
    ext_rom_addr = '0;
    if (issue) begin
      if (pos_q == '0)
        ext_rom_addr = EXT_ADDR_WIDTH'(WEIGHT_BASE + int'(idx_q) * KK
                       + int'(ti_q) * KERNEL_SIZE + int'(tj_q));
      else
        ext_rom_addr = EXT_ADDR_WIDTH'((int'(ti_q) + int'(row_q)) * IMAGE_SIZE
                       + int'(pos_q) - 1 + int'(tj_q));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ti_q       <= '0;
      tj_q       <= '0;
      pos_q      <= '0;
      pend_q     <= 1'b0;
      pend_pos_q <= '0;
      idx_q      <= '0;
      row_q      <= '0;
      w_q        <= '0;
      for (int a = 0; a < ARRAY_SIZE; a++) acc_q[a] <= '0;
    end else begin
      pend_q     <= issue && enable;
      pend_pos_q <= pos_q;
      if (pend_q && pend_pos_q == '0) w_q <= $signed(ext_rom_data);
      for (int a = 0; a < ARRAY_SIZE; a++)
        if (pend_q && pend_pos_q == PW'(a + 1))
          acc_q[a] <= acc_q[a] + ACC_W'(prod);
      if (issue) begin
        if (pos_q == P_LAST) begin
          pos_q <= '0;
          if (tj_q == T_LAST) begin
            tj_q <= '0;
            ti_q <= ti_q + TW'(1);
          end else begin
            tj_q <= tj_q + TW'(1);
          end
        end else begin
          pos_q <= pos_q + PW'(1);
        end
      end
      if (start || hs) begin
        ti_q  <= '0;
        tj_q  <= '0;
        pos_q <= '0;
        for (int a = 0; a < ARRAY_SIZE; a++) acc_q[a] <= '0;
      end
      if (start) begin
        idx_q <= '0;
        row_q <= '0;
      end else if (hs) begin
        if (last_row) begin
          idx_q <= '0;
          row_q <= '0;
        end else if (row_q == R_LAST) begin
          row_q <= '0;
          idx_q <= idx_q + IW'(1);
        end else begin
          row_q <= row_q + RW'(1);
        end
      end
    end
  end

  always_comb begin
    logic signed [ACC_W-1:0] sh;
    feature_output = '0;
    for (int a = 0; a < ARRAY_SIZE; a++) begin
      sh = acc_q[a] >>> FRAC_BITS;
      if (sh > SMAX)      sh = SMAX;
      else if (sh < SMIN) sh = SMIN;
      if (feature_valid)
        feature_output[(ARRAY_SIZE-1-a)*DATA_WIDTH +: DATA_WIDTH] =
          sh[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_conv_layer_engine.sv
// tb_conv_layer_engine: ROM-backed random stimulus against a
// direct convolution reference model.
module tb_conv_layer_engine;

  localparam int DW  = 16;
  localparam int IMG = 8;
  localparam int K   = 3;
  localparam int A   = 6;
  localparam int NK  = 3;
  localparam int WB  = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [11:0]   ext_rom_addr;
  logic [DW-1:0] ext_rom_data = '0;
  logic          feature_valid;
  logic          feature_ready = 1'b0;
  logic [A*DW-1:0] feature_output;
  logic [1:0]    feature_idx;
  logic [2:0]    feature_row;
  logic          busy;
  logic          image_calc_fin;

  logic [15:0] rom [0:4095];
  int checks = 0;
  int errors = 0;
  int fin_cnt = 0;

  conv_layer_engine dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .ext_rom_addr(ext_rom_addr), .ext_rom_data(ext_rom_data),
    .feature_valid(feature_valid), .feature_ready(feature_ready),
    .feature_output(feature_output), .feature_idx(feature_idx),
    .feature_row(feature_row), .busy(busy),
    .image_calc_fin(image_calc_fin)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ext_rom_data <= rom[ext_rom_addr];

  always @(negedge clk) if (image_calc_fin) fin_cnt <= fin_cnt + 1;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [A*DW-1:0] ref_row(input int k, input int r);
    logic [A*DW-1:0] o;
    longint s;
    o = '0;
    for (int a = 0; a < A; a++) begin
      s = 0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          s += longint'($signed(rom[(r + i) * IMG + a + j]))
             * longint'($signed(rom[WB + k * K * K + i * K + j]));
      s = s >>> 8;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      o[(A-1-a)*DW +: DW] = 16'(s);
    end
    return o;
  endfunction

  function automatic int exp_addr(input int k, input int r, input int c);
    int t, p;
    t = c / (A + 1);
    p = c % (A + 1);
    if (p == 0) return WB + k * K * K + t;
    return (r + t / K) * IMG + (p - 1) + t % K;
  endfunction

  task automatic fill(input int mode);
    for (int x = 0; x < WB + NK * K * K; x++) begin
      case (mode)
        0: rom[x] = 16'h0100;
        1: rom[x] = 16'($urandom_range(0, 1023) - 512);
        2: rom[x] = 16'($urandom);
        3: rom[x] = 16'h7FFF;
        default: rom[x] = (x >= WB) ? 16'h8000 : 16'h7FFF;
      endcase
    end
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    @(negedge clk);
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("start_busy", busy, 1);
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_valid"}, feature_valid, 0);
    check({tag, "_out"}, feature_output, 0);
    check({tag, "_idx"}, feature_idx, 0);
    check({tag, "_row"}, feature_row, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fin"}, image_calc_fin, 0);
    check({tag, "_addr"}, ext_rom_addr, 0);
  endtask

  // stall_mode: 0 none, 1 random 0..3 cycles, 2 five cycles on one row
  task automatic run_image(input int stall_mode, input bit keep_en);
    int cyc, s, f0;
    logic [A*DW-1:0] exp;
    f0 = fin_cnt;
    feature_ready = 1'b1;
    enable = 1'b1;
    wait_busy();
    for (int k = 0; k < NK; k++) begin
      for (int r = 0; r < A; r++) begin
        cyc = 0;
        while (!feature_valid && cyc < 200) begin
          if (cyc < 14) check("addr", ext_rom_addr, exp_addr(k, r, cyc));
          @(negedge clk);
          cyc++;
        end
        check("latency", cyc, 64);
        exp = ref_row(k, r);
        check("out", feature_output, exp);
        check("idx", feature_idx, k);
        check("row", feature_row, r);
        if (stall_mode == 1) s = $urandom_range(0, 3);
        else if (stall_mode == 2 && k == 0 && r == 1) s = 5;
        else s = 0;
        if (s > 0) begin
          feature_ready = 1'b0;
          repeat (s) begin
            @(negedge clk);
            check("hold_valid", feature_valid, 1);
            check("hold_out", feature_output, exp);
            check("hold_idx", feature_idx, k);
            check("hold_row", feature_row, r);
            check("hold_addr", ext_rom_addr, 0);
          end
          feature_ready = 1'b1;
        end
        @(negedge clk);
        if (k == NK - 1 && r == A - 1) begin
          check("fin", image_calc_fin, 1);
          check("fin_out", feature_output, 0);
          if (!keep_en) enable = 1'b0;
        end else begin
          check("hs_valid", feature_valid, 0);
        end
      end
    end
    @(negedge clk);
    check("fin_pulse", image_calc_fin, 0);
    check("fin_count", fin_cnt, f0 + 1);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int f0, sawv;
    repeat (3) @(negedge clk);
    check_idle_outs("reset");
    rst_n = 1'b1;

    fill(0);
    run_image(2, 1'b1);
    @(negedge clk);
    check("restart_busy", busy, 1);
    check("restart_addr", ext_rom_addr, WB);
    enable = 1'b0;
    @(negedge clk);
    check("stop_busy", busy, 0);

    fill(1);
    run_image(1, 1'b0);
    fill(2);
    run_image(1, 1'b0);
    fill(3);
    run_image(0, 1'b0);
    fill(4);
    run_image(0, 1'b0);

    fill(1);
    f0 = fin_cnt;
    enable = 1'b1;
    wait_busy();
    repeat (30) @(negedge clk);
    check("abort_busy_c30", busy, 1);
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy_c31", busy, 0);
    sawv = 0;
    repeat (100) begin
      @(negedge clk);
      if (feature_valid || busy) sawv = 1;
    end
    check("abort_quiet", sawv, 0);
    check("abort_fin", fin_cnt, f0);
    run_image(0, 1'b0);

    fill(0);
    enable = 1'b1;
    wait_busy();
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outs("rst_mid");
    @(negedge clk);
    enable = 1'b0;
    check_idle_outs("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    run_image(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
